// File: rtl/ddi_phase_fsm_pkg.sv
// Shared encodings for the diverging-diamond phase sequencer: state codes,
// next-phase codes, lamp bit positions and small decode helpers.
package ddi_phase_fsm_pkg;

   typedef enum logic [3:0] {
      ALL_RED          = 4'd0,
      PHASE_1_GREEN    = 4'd1,
      PHASE_1_YELLOW   = 4'd2,
      PHASE_2_GREEN    = 4'd3,
      PHASE_2_YELLOW   = 4'd4,
      EASTBOUND_GREEN  = 4'd5,
      EASTBOUND_YELLOW = 4'd6,
      WESTBOUND_GREEN  = 4'd7,
      WESTBOUND_YELLOW = 4'd8,
      MAINTENANCE      = 4'd9
   } state_e;

   typedef enum logic [1:0] {
      P1 = 2'd0,
      P2 = 2'd1,
      EB = 2'd2,
      WB = 2'd3
   } phase_e;

   localparam int RED    = 2;
   localparam int YELLOW = 1;
   localparam int GREEN  = 0;

   typedef logic [2:0] lamp_t;

   function automatic lamp_t lamp_of(input logic is_green, input logic is_yellow);
      lamp_t l;
      l = '0;
      if (is_green)       l[GREEN]  = 1'b1;
      else if (is_yellow) l[YELLOW] = 1'b1;
      else                l[RED]    = 1'b1;
      return l;
   endfunction

   function automatic state_e green_of(input phase_e p);
      case (p)
         P1:      return PHASE_1_GREEN;
         P2:      return PHASE_2_GREEN;
         EB:      return EASTBOUND_GREEN;
         default: return WESTBOUND_GREEN;
      endcase
   endfunction

endpackage

// File: rtl/ddi_phase_fsm_if.sv
// Bundle between the phase sequencer (slave) and its environment (master):
// timing handshake, detector demands, state bus, lamps and demand status.
interface ddi_phase_fsm_if;
   logic       timing_done;
   logic       eb_req;
   logic       wb_req;
   logic       maint_req;
   logic [3:0] current_state;
   logic [2:0] p1_lamp;
   logic [2:0] p2_lamp;
   logic [2:0] eb_lamp;
   logic [2:0] wb_lamp;
   logic       eb_pending;
   logic       wb_pending;

   modport master (
      output timing_done, eb_req, wb_req, maint_req,
      input  current_state, p1_lamp, p2_lamp, eb_lamp, wb_lamp, eb_pending, wb_pending
   );

   modport slave (
      input  timing_done, eb_req, wb_req, maint_req,
      output current_state, p1_lamp, p2_lamp, eb_lamp, wb_lamp, eb_pending, wb_pending
   );
endinterface

// File: rtl/ddi_phase_fsm_maint_flasher.sv
// Half-period counter for the maintenance red flash; idles cleared while
// enable_i is low so every maintenance entry starts with the lamps dark.
module maint_flasher #(
   parameter int FLASH_TICKS = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable_i,
   output logic flash_o
);

   localparam logic [7:0] LAST_TICK = 8'(FLASH_TICKS - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       flash_q, flash_d;

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      cnt_d   = cnt_q;
      flash_d = flash_q;
      if (!enable_i) begin
         cnt_d   = '0;
         flash_d = 1'b0;
      end else if (cnt_q == LAST_TICK) begin
         cnt_d   = '0;
         flash_d = ~flash_q;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         flash_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         flash_q <= flash_d;
      end
   end

   assign flash_o = flash_q;

endmodule

// File: rtl/ddi_phase_fsm.sv
// Master signal-phase sequencer: crossover phases, demand-served turn phases,
// all-red clearance and a flashing-red maintenance mode.
module ddi_phase_fsm
   import ddi_phase_fsm_pkg::*;
#(
   parameter int FLASH_TICKS = 50
) (
   input logic             clk,
   input logic             rst_n,
   ddi_phase_fsm_if.slave  bus
);

   state_e state_q, state_d;
   phase_e next_phase_q, next_phase_d;
   logic   eb_pending_q, eb_pending_d;
   logic   wb_pending_q, wb_pending_d;
   logic   guard_q, guard_d;
   logic   flash;
   logic   td_qual;

   // The guard masks the done flag timing_controller still holds from the
   // previous state (notably the permanently-high one during maintenance).
   assign td_qual = bus.timing_done & ~guard_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ALL_RED;
         next_phase_q <= P1;
         eb_pending_q <= 1'b0;
         wb_pending_q <= 1'b0;
         guard_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         next_phase_q <= next_phase_d;
         eb_pending_q <= eb_pending_d;
         wb_pending_q <= wb_pending_d;
         guard_q      <= guard_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      next_phase_d = next_phase_q;
      case (state_q)
         ALL_RED:
            if (td_qual) state_d = bus.maint_req ? MAINTENANCE : green_of(next_phase_q);
         PHASE_1_GREEN:    if (td_qual) state_d = PHASE_1_YELLOW;
         PHASE_2_GREEN:    if (td_qual) state_d = PHASE_2_YELLOW;
         EASTBOUND_GREEN:  if (td_qual) state_d = EASTBOUND_YELLOW;
         WESTBOUND_GREEN:  if (td_qual) state_d = WESTBOUND_YELLOW;
         PHASE_1_YELLOW:
            if (td_qual) begin
               state_d      = ALL_RED;
               next_phase_d = P2;
            end
         PHASE_2_YELLOW:
            if (td_qual) begin
               state_d      = ALL_RED;
               next_phase_d = eb_pending_q ? EB : (wb_pending_q ? WB : P1);
            end
         EASTBOUND_YELLOW:
            if (td_qual) begin
               state_d      = ALL_RED;
               next_phase_d = wb_pending_q ? WB : P1;
            end
         WESTBOUND_YELLOW:
            if (td_qual) begin
               state_d      = ALL_RED;
               next_phase_d = P1;
            end
         MAINTENANCE:
            if (!bus.maint_req) begin
               state_d      = ALL_RED;
               next_phase_d = P1;
            end
         default: state_d = ALL_RED;
      endcase
   end

   assign guard_d = (state_d != state_q);

   // Clearing on entry to the turn green wins over a request in the same cycle;
   // requests during the approach's own green/yellow are already being served.
   always_comb begin
      eb_pending_d = eb_pending_q;
      wb_pending_d = wb_pending_q;
      if (state_d == EASTBOUND_GREEN && state_q != EASTBOUND_GREEN)
         eb_pending_d = 1'b0;
      else if (bus.eb_req && !(state_q inside {EASTBOUND_GREEN, EASTBOUND_YELLOW}))
         eb_pending_d = 1'b1;
      if (state_d == WESTBOUND_GREEN && state_q != WESTBOUND_GREEN)
         wb_pending_d = 1'b0;
      else if (bus.wb_req && !(state_q inside {WESTBOUND_GREEN, WESTBOUND_YELLOW}))
         wb_pending_d = 1'b1;
   end

   maint_flasher #(.FLASH_TICKS(FLASH_TICKS)) u_flasher (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable_i (state_q == MAINTENANCE),
      .flash_o  (flash)
   );

   always_comb begin
      if (state_q == MAINTENANCE) begin
         bus.p1_lamp = {flash, 2'b00};
         bus.p2_lamp = {flash, 2'b00};
         bus.eb_lamp = {flash, 2'b00};
         bus.wb_lamp = {flash, 2'b00};
      end else begin
         bus.p1_lamp = lamp_of(state_q == PHASE_1_GREEN,   state_q == PHASE_1_YELLOW);
         bus.p2_lamp = lamp_of(state_q == PHASE_2_GREEN,   state_q == PHASE_2_YELLOW);
         bus.eb_lamp = lamp_of(state_q == EASTBOUND_GREEN, state_q == EASTBOUND_YELLOW);
         bus.wb_lamp = lamp_of(state_q == WESTBOUND_GREEN, state_q == WESTBOUND_YELLOW);
      end
   end

   assign bus.current_state = state_q;
   assign bus.eb_pending    = eb_pending_q;
   assign bus.wb_pending    = wb_pending_q;

endmodule

// File: doc/ddi_phase_fsm.md
Name: ddi_phase_fsm

Overview:
Master signal-phase state machine for the diverging-diamond interchange. It sequences both crossover phases (PHASE_1, PHASE_2) and the demand-served eastbound/westbound turn phases through green, yellow and all-red. It drives the 4-bit `current_state` bus consumed by `timing_controller` and consumes that block's `timing_done` pulse. It also decodes per-approach lamp outputs and runs a flashing-red maintenance mode.

Parameters:
FLASH_TICKS, 50, clock cycles per half-period of the maintenance red flash (1..255).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
timing_done  input  1  dwell-complete flag from timing_controller.
eb_req  input  1  eastbound detector demand, pulse or level.
wb_req  input  1  westbound detector demand, pulse or level.
maint_req  input  1  maintenance request, level.
current_state  output  4  registered FSM state, fsm_parameters encoding.
p1_lamp  output  3  {red,yellow,green}, phase-1 approach.
p2_lamp  output  3  {red,yellow,green}, phase-2 approach.
eb_lamp  output  3  {red,yellow,green}, eastbound turn.
wb_lamp  output  3  {red,yellow,green}, westbound turn.
eb_pending  output  1  latched eastbound demand.
wb_pending  output  1  latched westbound demand.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- State encodings (fsm_parameters):
  - ALL_RED=0, PHASE_1_GREEN=1, PHASE_1_YELLOW=2, PHASE_2_GREEN=3, PHASE_2_YELLOW=4.
  - EASTBOUND_GREEN=5, EASTBOUND_YELLOW=6, WESTBOUND_GREEN=7, WESTBOUND_YELLOW=8, MAINTENANCE=9.
  - Codes 10-15 are illegal; the FSM recovers to ALL_RED on the next edge.
- Reset values (asynchronous, rst_n low):
  - current_state=ALL_RED, next_phase=P1, eb_pending=0, wb_pending=0, flash=0, entry_guard=1.
  - Lamps therefore read 3'b100 on every approach.
- Entry guard:
  - entry_guard is set on reset and on every state change, and cleared on the following cycle.
  - timing_done is ignored while entry_guard=1. This blocks the stale timing_done that timing_controller holds high during MAINTENANCE (threshold 0).
- Transitions (edge where qualified timing_done=1):
  - Green -> matching yellow.
  - Yellow -> ALL_RED, updating next_phase:
    - after P1Y: next_phase=P2.
    - after P2Y: next_phase=EB if eb_pending, else WB if wb_pending, else P1.
    - after EBY: next_phase=WB if wb_pending, else P1.
    - after WBY: next_phase=P1.
  - ALL_RED -> MAINTENANCE if maint_req=1, else green of next_phase.
- MAINTENANCE:
  - timing_done is ignored.
  - While maint_req=1 the state holds.
  - When maint_req=0: go to ALL_RED with next_phase=P1 and the pending latches untouched.
  - maint_req during a green or yellow never truncates it; it takes effect only at the end of ALL_RED.
- Demand latches:
  - eb_req=1 sets eb_pending; the latch clears on the edge entering EASTBOUND_GREEN. Clear wins over a coincident set.
  - Requests during that approach's own green or yellow are dropped.
  - wb_req and wb_pending behave identically.
- Lamps (combinational decode of the registered state and flash):
  - The approach in its green shows 001; in its yellow, 010; otherwise 100.
  - In MAINTENANCE every lamp is {flash,0,0}.
- Flash counter:
  - 8-bit, runs only in MAINTENANCE and is cleared to 0 (flash=0) outside it.
  - flash toggles every FLASH_TICKS cycles, so the first lit half-period starts FLASH_TICKS cycles after entry.
- Dwell with timing_controller: every timed state lasts threshold+1 cycles (GREEN_TICKS+1, YELLOW_TICKS+1, RED_TICKS+1).
- Reset mid-operation: immediate ALL_RED and all latches cleared, regardless of state.

Decomposition:
- fsm_parameters.v (shared) holds the state codes above, the next_phase codes P1=0, P2=1, EB=2, WB=3, and the lamp bit indices RED=2, YELLOW=1, GREEN=0.
- One sub-module, maint_flasher (enable, FLASH_TICKS counter, flash output).
- The FSM, guard, demand latches and lamp decode stay in ddi_phase_fsm.

Test Plan:
1. Release rst_n, no requests, timing stub pulsing timing_done 3 cycles after each entry -> states 0,1,2,0,3,4,0,1; all lamps 100 in state 0.
2. eb_req 1-cycle pulse during PHASE_1_GREEN -> eb_pending=1; after P2Y, ALL_RED then state 5 with eb_lamp=001; eb_pending=0 on entry.
3. eb_req and wb_req both pulsed during PHASE_2_GREEN -> sequence 3,4,0,5,6,0,7,8,0,1; both pendings cleared.
4. maint_req=1 during PHASE_2_GREEN, timing_done stuck at 1 in state 9 -> P2Y completes, state 0, then 9. With FLASH_TICKS=4, reds toggle every 4 cycles. Drop maint_req -> state 0, held until a fresh timing_done (not the stale one), then state 1.
5. Assert rst_n=0 asynchronously mid-EASTBOUND_GREEN with wb_pending=1 -> current_state=0 before the next edge, wb_pending=0, lamps 100.
6. Integrated with timing_controller, GREEN_TICKS=10 -> PHASE_1_GREEN lasts exactly 11 cycles, yellow YELLOW_TICKS+1, red RED_TICKS+1.
